// File: rtl/vga_fb_scanout_if.sv
// -----------------------------------------------------------------------------
// vga_fb_scanout_if
// Read port (port B) of the dual-port pixel RAM as seen by the scanout engine.
//   Rd_addr  RAM read address, driven by the scanout engine
//   Rd_en    read enable, high only while a visible pixel is being fetched
//   Rd_data  RAM read data, returned by the RAM side
// Modports:
//   master   scanout engine (drives address/enable, receives data)
//   slave    RAM (receives address/enable, drives data)
// -----------------------------------------------------------------------------
interface vga_fb_scanout_if #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned RGB_W  = 12
);
  logic [ADDR_W-1:0] Rd_addr;
  logic              Rd_en;
  logic [RGB_W-1:0]  Rd_data;

  modport master (output Rd_addr, output Rd_en, input Rd_data);
  modport slave  (input Rd_addr, input Rd_en, output Rd_data);
endinterface

// File: rtl/vga_fb_scanout.sv
// -----------------------------------------------------------------------------
// vga_fb_scanout
// Parametrised VGA timing generator and framebuffer read engine. Produces
// H/V sync and blanking from the timing parameters, fetches pixels from the
// frame buffer through the RAM read port and presents RGB, sync and Active
// aligned to each other. Supports a per-frame base address (double
// buffering) and a 2x2 pixel-doubling mode for half-resolution images.
// Ports:
//   Clk_100M     system clock
//   Reset_n      asynchronous active-low reset
//   Base_addr    frame buffer start address, sampled at frame start
//   Scale2x      0 = 1:1 scan, 1 = each source pixel shown 2x2; sampled at
//                frame start
//   ramRd        RAM read port (Rd_addr, Rd_en out; Rd_data in)
//   Hsync/Vsync  sync outputs, asserted level SYNC_POL
//   RGB          pixel output, 0 outside the visible region
//   Active       high while RGB carries a visible pixel
//   Frame_start  one-clock pulse on the pixel clock enable of pixel (0,0)
// -----------------------------------------------------------------------------
module vga_fb_scanout #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned RGB_W     = 12,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned RAM_LAT   = 1
) (
  input  logic              Clk_100M,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Base_addr,
  input  logic              Scale2x,
  vga_fb_scanout_if.master  ramRd,
  output logic              Hsync,
  output logic              Vsync,
  output logic [RGB_W-1:0]  RGB,
  output logic              Active,
  output logic              Frame_start
);

  // Read data must have settled before the next pixel enable samples it.
  if (CLK_DIV < 2 || CLK_DIV <= RAM_LAT) begin : g_bad_cfg
    $error("vga_fb_scanout: CLK_DIV must be >= 2 and > RAM_LAT");
  end

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam int unsigned HW = $clog2(H_TOTAL + 1);
  localparam int unsigned VW = $clog2(V_TOTAL + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_VIS_LAST = HW'(H_VISIBLE - 1);
  localparam logic [HW-1:0] HS_BEG     = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END     = HW'(H_VISIBLE + H_FRONT + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0]     div;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic              scaleSh;
  logic [ADDR_W-1:0] addrPtr;    // address of the next visible pixel
  logic [ADDR_W-1:0] lineStart;  // first address of the current line
  logic [ADDR_W-1:0] rdAddr;
  logic              rdEn;
  logic              hs1;
  logic              vs1;

  logic              pixCe;
  logic              firstPix;
  logic              visible;
  logic              hsAct;
  logic              vsAct;
  logic              scaleNow;
  logic [ADDR_W-1:0] addrNow;
  logic [ADDR_W-1:0] addrInc;
  logic [ADDR_W-1:0] addrNext;

  assign pixCe    = (div == DIV_LAST);
  assign firstPix = (hcnt == '0) && (vcnt == '0);
  assign visible  = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hsAct    = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vsAct    = (vcnt >= VS_BEG) && (vcnt < VS_END);

  // Pixel (0,0) takes base and mode straight from the inputs on the same
  // enable that latches them, so no separate base shadow is needed: the
  // base lives on in addrPtr for the rest of the frame.
  assign scaleNow = firstPix ? Scale2x : scaleSh;
  assign addrNow  = firstPix ? Base_addr : addrPtr;
  assign addrInc  = addrNow + ADDR_W'(1);

  // 2x mode: advance on odd columns only; at the end of an even line rewind
  // so the following line re-reads the same source row.
  always_comb begin
    addrNext = addrNow;
    if (!scaleNow) begin
      addrNext = addrInc;
    end else if ((hcnt == H_VIS_LAST) && !vcnt[0]) begin
      addrNext = lineStart;
    end else if (hcnt[0]) begin
      addrNext = addrInc;
    end
  end

  always_ff @(posedge Clk_100M or negedge Reset_n) begin
    if (!Reset_n) begin
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      scaleSh     <= 1'b0;
      addrPtr     <= '0;
      lineStart   <= '0;
      rdAddr      <= '0;
      rdEn        <= 1'b0;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      RGB         <= '0;
      Active      <= 1'b0;
      Hsync       <= ~SYNC_POL;
      Vsync       <= ~SYNC_POL;
      Frame_start <= 1'b0;
    end else begin
      div <= pixCe ? '0 : div + DW'(1);

      // Registered one clock early so the pulse coincides with pixCe.
      Frame_start <= (div == DIV_PRE) && firstPix;

      if (pixCe) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
        end else begin
          hcnt <= hcnt + HW'(1);
        end

        if (firstPix) begin
          scaleSh <= Scale2x;
        end

        // Stage 1: address issue.
        rdEn <= visible;
        if (visible) begin
          rdAddr  <= addrNow;
          addrPtr <= addrNext;
          if (hcnt == '0) begin
            lineStart <= addrNow;
          end
        end
        hs1 <= hsAct;
        vs1 <= vsAct;

        // Stage 2: outputs, all one pixel behind stage 1.
        RGB    <= rdEn ? ramRd.Rd_data : '0;
        Active <= rdEn;
        Hsync  <= hs1 ? SYNC_POL : ~SYNC_POL;
        Vsync  <= vs1 ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  assign ramRd.Rd_addr = rdAddr;
  assign ramRd.Rd_en   = rdEn;

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
Parametrised VGA timing generator and framebuffer read engine.
- Replaces the fixed 640x480, divide-by-4 scanout logic in the top level.
- Generates sync and blanking from parameters and drives the read port (port B) of the dual-port pixel RAM.
- Presents aligned RGB/sync to the pins.
- Adds two things the current logic lacks: a runtime base address for double-buffering, and a 2x pixel-doubling mode for half-resolution Mandelbrot renders.

Parameters:
CLK_DIV, 4, system clocks per pixel; must be >= 2 and > RAM_LAT
H_VISIBLE, 640, visible pixels per line (even)
H_FRONT, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BACK, 48, horizontal back porch, pixels
V_VISIBLE, 480, visible lines (even)
V_FRONT, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BACK, 33, vertical back porch, lines
SYNC_POL, 0, asserted level of Hsync/Vsync
RGB_W, 12, pixel width
ADDR_W, 19, RAM address width
RAM_LAT, 1, RAM read latency, system clocks

Ports:
Clk_100M  in  1  system clock
Reset_n  in  1  async active-low reset
Base_addr  in  ADDR_W  framebuffer start address; sampled at frame start
Scale2x  in  1  0 = 1:1 scan; 1 = each source pixel shown 2x2; sampled at frame start
Rd_addr  out  ADDR_W  RAM read address
Rd_en  out  1  read enable; high only for visible pixels
Rd_data  in  RGB_W  RAM read data, valid RAM_LAT clocks after Rd_addr
Hsync  out  1  horizontal sync
Vsync  out  1  vertical sync
RGB  out  RGB_W  pixel out; 0 outside the visible region
Active  out  1  high while RGB is a visible pixel
Frame_start  out  1  one-clock pulse at pixel (0,0)

Behaviour:
Reset (async, Reset_n=0):
- All counters 0; Rd_addr=0, Rd_en=0, RGB=0, Active=0, Frame_start=0.
- Hsync=Vsync=~SYNC_POL.
- Reset mid-frame aborts the frame immediately; scan restarts at (0,0) after release.

Pixel enable:
- Divider div counts 0..CLK_DIV-1 and wraps.
- pix_ce=1 on the clock where div==CLK_DIV-1. All scan state advances only on pix_ce.

Counters:
- H_TOTAL = sum of H params; V_TOTAL = sum of V params.
- hcnt runs 0..H_TOTAL-1; wrap increments vcnt.
- vcnt runs 0..V_TOTAL-1, then wraps to 0.
- Region order: visible, front porch, sync, back porch.
- Sync asserted for hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), and likewise for vcnt.

Frame start:
- On pix_ce with (hcnt,vcnt)=(0,0): latch Base_addr and Scale2x into shadow registers, and pulse Frame_start for that one clock.
- Mid-frame changes to Base_addr or Scale2x have no effect until the next frame.

Stage 1 (address issue), on pix_ce:
- Visible pixel (hcnt<H_VISIBLE, vcnt<V_VISIBLE): Rd_en=1, Rd_addr=next address.
- Otherwise Rd_en=0 and Rd_addr holds.

1:1 addressing:
- Address = base + vcnt*H_VISIBLE + hcnt.
- Computed incrementally; no multiplier.

2x addressing:
- Address = base + (vcnt>>1)*(H_VISIBLE/2) + (hcnt>>1).
- Each address is issued on two consecutive pixels.
- After an even line, rewind to that line's start address. After an odd line, continue.

Stage 2 (output), on the next pix_ce:
- RGB <= Rd_data if the stage-1 pixel was visible, else 0.
- Hsync, Vsync and Active are registered in the same stage, so all outputs are aligned.
- Latency is one pixel period from Rd_addr to RGB.
- CLK_DIV > RAM_LAT guarantees Rd_data is valid at sampling.

Address arithmetic:
- Width ADDR_W, modulo 2^ADDR_W; wrap is silent.
- Base plus frame size overflowing the RAM is the caller's responsibility.

Test Plan:
1. Reset held 10 clocks with defaults -> Hsync=Vsync=1, RGB=0, Active=0, Rd_en=0. Release -> first Frame_start at clock 4 (first pix_ce).
2. Free-run one frame, defaults -> Hsync low for 384 clocks every 3200 clocks, beginning 2624 clocks after line start. Vsync low for 2 lines (6400 clocks) starting at line 490. Frame_start period 1,680,000 clocks.
3. Scale2x=0, Base=0, RAM loaded with data=addr -> Rd_addr runs 0..639 on line 0, 640 on line 1, 307199 last. RGB lags Rd_addr by exactly 4 clocks with Active high; RGB=0 in blanking.
4. Scale2x=1, Base=0 -> lines 0 and 1 both read 0,0,1,1,...,319,319. Line 2 starts at 320. Last visible address 76799.
5. Base_addr changed 0->76800 and Scale2x 0->1 at line 100 -> current frame unaffected. Next frame's first Rd_addr=76800 with doubling.
6. Reset_n pulsed low at hcnt=300, line 200 -> outputs take reset values asynchronously. After release, scan restarts at (0,0) with Frame_start.
